// File: rtl/spi_reg_ctrl.sv
// SPI command/register controller: frames on cs_n, decodes a command byte and
// streams burst reads/writes against a 16 x 8 register file with auto-increment.
module spi_reg_ctrl #(
    parameter logic [7:0]  ID_VALUE  = 8'hA5,
    parameter int unsigned DISP_ADDR = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic [7:0] rx_data,
    input  logic       rx_full,
    output logic [7:0] tx_data,
    output logic       tx_send,
    output logic [7:0] disp_reg,
    output logic [7:0] frame_cnt,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] DISP_IDX = 4'(DISP_ADDR);

    typedef enum logic [1:0] {IDLE, CMD, DATA, IGNORE} state_t;

    state_t     state, state_nxt;
    logic       full_q;
    logic       rw, rw_nxt;
    logic [3:0] addr, addr_nxt;
    logic [7:0] regs [14];
    logic [7:0] rd_mux [16];
    logic [7:0] tx_nxt, frame_nxt, err_nxt;
    logic       send_nxt, wr_en;
    logic       byte_ev, cmd_ok;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign byte_ev = rx_full & ~full_q & ~cs_n;
    assign cmd_ok  = (rx_data[6:4] == 3'b000);

    // Read view of the full 16-entry map, including the two read-only slots
    always_comb begin
        for (int i = 0; i < 14; i++) rd_mux[i] = regs[i];
        rd_mux[14] = ID_VALUE;
        rd_mux[15] = frame_cnt;
    end

    assign disp_reg = rd_mux[DISP_IDX];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_n) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = CMD;
                CMD:     if (byte_ev) state_nxt = cmd_ok ? DATA : IGNORE;
                default: state_nxt = state;
            endcase
        end
    end

    // cs_n high takes priority, so a byte arriving with the chip-select release is dropped
    always_comb begin
        send_nxt  = 1'b0;
        tx_nxt    = tx_data;
        addr_nxt  = addr;
        rw_nxt    = rw;
        wr_en     = 1'b0;
        err_nxt   = err_cnt;
        frame_nxt = frame_cnt;
        if (cs_n) begin
            if (state == DATA) frame_nxt = frame_cnt + 8'd1;
        end else begin
            case (state)
                CMD: begin
                    if (byte_ev) begin
                        if (cmd_ok) begin
                            rw_nxt   = rx_data[7];
                            addr_nxt = rx_data[3:0];
                            tx_nxt   = rd_mux[rx_data[3:0]];
                            send_nxt = 1'b1;
                        end else begin
                            err_nxt  = sat_inc(err_cnt);
                        end
                    end
                end
                DATA: begin
                    if (byte_ev) begin
                        wr_en    = rw && (addr < 4'd14);
                        addr_nxt = addr + 4'd1;
                        tx_nxt   = rd_mux[addr + 4'd1];
                        send_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 1'b0;
            rw        <= 1'b0;
            addr      <= 4'd0;
            tx_data   <= 8'd0;
            tx_send   <= 1'b0;
            frame_cnt <= 8'd0;
            err_cnt   <= 8'd0;
            for (int i = 0; i < 14; i++) regs[i] <= 8'd0;
        end else begin
            full_q    <= rx_full;
            rw        <= rw_nxt;
            addr      <= addr_nxt;
            tx_data   <= tx_nxt;
            tx_send   <= send_nxt;
            frame_cnt <= frame_nxt;
            err_cnt   <= err_nxt;
            if (wr_en) regs[addr] <= rx_data;
        end
    end

endmodule
